// File: rtl/imem_loader.sv
// Instruction-memory loader: buffers words from a GPIO source and writes them to IMEM from BASE_ADDR.
// Latency is 2 edges from accept to write, at 1 word/cycle. IN_READY drops when the FIFO is full or COUNT words are in.

// Small FIFO: flush empties it in one edge, read data is shown combinationally at the head.
module imem_loader_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_push_dat,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_pop_dat,
    output logic [$clog2(DEPTH):0] o_cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_cnt;

    always_ff @(posedge CLK) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_cnt     = r_cnt;
endmodule

module imem_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W:0]   COUNT,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              CORE_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              WRAP,
    output logic [ADDR_W:0]   LOADED
);
    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_acc;
    logic [ADDR_W:0]   r_loaded;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W:0]   w_acc_nxt;
    logic [ADDR_W:0]   w_loaded_nxt;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_wrap;

    logic              w_active;
    logic              w_abort;
    logic              w_start;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_fifo_cnt;
    logic [CW-1:0]     w_fifo_cnt_nxt;
    logic [DATA_W-1:0] w_fifo_dat;

    assign w_active = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_abort  = ABORT && (r_state != S_IDLE);
    assign w_start  = START && (r_state == S_IDLE);
    assign w_push   = (r_state == S_LOAD) && r_in_ready && IN_VALID && !ABORT;
    assign w_pop    = w_active && (w_fifo_cnt != '0) && !ABORT;

    imem_loader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .i_flush    (w_abort),
        .i_push     (w_push),
        .i_push_dat (IN_DATA),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_cnt      (w_fifo_cnt)
    );

    always_comb begin
        w_count_nxt  = r_count;
        w_acc_nxt    = r_acc + (ADDR_W+1)'(w_push);
        w_loaded_nxt = r_loaded + (ADDR_W+1)'(w_pop);
        if (w_start) begin
            w_count_nxt  = COUNT;
            w_acc_nxt    = '0;
            w_loaded_nxt = '0;
        end
    end

    always_comb begin
        w_fifo_cnt_nxt = w_fifo_cnt;
        if (w_abort) begin
            w_fifo_cnt_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_fifo_cnt_nxt = w_fifo_cnt + CW'(1);
        end else if (w_pop && !w_push) begin
            w_fifo_cnt_nxt = w_fifo_cnt - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = (COUNT == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_push && (w_acc_nxt == r_count)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((w_fifo_cnt_nxt == '0) && (w_loaded_nxt == r_count)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Abort overrides any transition, including the FINISH exit.
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_loaded    <= '0;
            r_wptr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_acc      <= w_acc_nxt;
            r_loaded   <= w_loaded_nxt;
            r_mem_we   <= w_pop;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_FINISH);
            r_in_ready <= (w_state_nxt == S_LOAD) && (w_fifo_cnt_nxt < LP_DEPTH) &&
                          (w_acc_nxt < w_count_nxt);
            if (w_start) begin
                r_wptr <= BASE_ADDR;
            end else if (w_pop) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_mem_addr  <= r_wptr;
                r_mem_wdata <= w_fifo_dat;
            end
            // Address 0 reached after at least one write means the previous write hit the top.
            if (w_start) begin
                r_wrap <= 1'b0;
            end else if (w_pop && (r_wptr == '0) && (r_loaded != '0)) begin
                r_wrap <= 1'b1;
            end
        end
    end

    assign IN_READY  = r_in_ready;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign CORE_HOLD = r_busy;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign WRAP      = r_wrap;
    assign LOADED    = r_loaded;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, instruction word width.
- ADDR_W, 8, instruction-memory address width.
- FIFO_DEPTH, 4, input buffer depth in words; power of two, at least 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock; all state updates on the rising edge.
- RST, in, 1, reset; asynchronous, active-low.
- START, in, 1, load request; sampled only in IDLE.
- ABORT, in, 1, cancels the load in progress.
- BASE_ADDR, in, ADDR_W, first write address; captured on START.
- COUNT, in, ADDR_W+1, number of words to load; captured on START.
- IN_VALID, in, 1, IN_DATA holds a word.
- IN_DATA, in, DATA_W, instruction word (GPIO source).
- IN_READY, out, 1, loader accepts a word this cycle.
- MEM_WE, out, 1, instruction-memory write strobe.
- MEM_ADDR, out, ADDR_W, write address.
- MEM_WDATA, out, DATA_W, write data.
- CORE_HOLD, out, 1, holds the CPU core while the loader is active.
- BUSY, out, 1, state is not IDLE.
- DONE, out, 1, one-cycle completion pulse.
- WRAP, out, 1, sticky flag: the write address wrapped past 2^ADDR_W-1.
- LOADED, out, ADDR_W+1, number of words written to memory since START.

Function
REQ-003 FSM states: IDLE, LOAD, DRAIN, FINISH; all outputs registered.
REQ-004 IDLE with START=1: capture BASE_ADDR and COUNT, clear LOADED and WRAP, go to LOAD; if COUNT=0, go to FINISH instead.
REQ-005 START outside IDLE is ignored.
REQ-006 IN_READY = 1 only in LOAD, with the FIFO not full and accepted-word count < captured COUNT.
REQ-007 Transfer occurs on an edge where IN_VALID=1 and IN_READY=1: push IN_DATA into the FIFO and increment the accepted count; IN_DATA is ignored otherwise.
REQ-008 LOAD goes to DRAIN on the edge where the accepted count reaches COUNT.
REQ-009 In LOAD or DRAIN with the FIFO non-empty, each edge pops one word and drives, in the following cycle, MEM_WE=1, MEM_WDATA=word, MEM_ADDR=write pointer.
- The write pointer increments after each write.
- LOADED increments after each write.
- In all other cycles MEM_WE=0.
REQ-010 Latency: a word accepted at edge k is written (MEM_WE high) in the cycle after edge k+1; throughput is 1 word per cycle.
REQ-011 A push and a pop on the same edge are both performed; the FIFO count is unchanged.
REQ-012 IN_READY is deasserted when the FIFO is full, even if a pop occurs that edge.
REQ-013 The write pointer wraps modulo 2^ADDR_W; WRAP is set on the write that follows the write to address 2^ADDR_W-1 and holds until the next accepted START.
REQ-014 DRAIN goes to FINISH on the edge where the FIFO becomes empty and LOADED equals COUNT.
REQ-015 FINISH lasts one cycle: DONE=1, then IDLE.
REQ-016 BUSY and CORE_HOLD are 1 in LOAD, DRAIN and FINISH, and 0 in IDLE.
REQ-017 ABORT=1 in any non-IDLE state:
- flush the FIFO and go to IDLE on that edge;
- no DONE pulse, no further MEM_WE;
- LOADED and WRAP keep their values.
REQ-018 ABORT takes priority over transfers and over state transitions; ABORT in IDLE has no effect.

Reset
REQ-019 RST=0 asynchronously forces:
- state IDLE, FIFO empty, write pointer 0;
- IN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0;
- CORE_HOLD=0, BUSY=0, DONE=0, WRAP=0, LOADED=0.
REQ-020 Reset asserted mid-load discards all buffered words; operation resumes on the first rising edge after RST returns to 1.

Verification
REQ-021 Basic load: START, BASE_ADDR=0x10, COUNT=3, words 0x20080005, 0x20090003, 0x01095020 with IN_VALID held high -> writes to 0x10, 0x11, 0x12 in consecutive cycles, DONE pulses once, LOADED=3, BUSY=0 afterwards.
REQ-022 Backpressure: DATA_W=32, FIFO_DEPTH=4, COUNT=8, with the sink forced stalled by holding the state in LOAD -> IN_READY drops when the FIFO is full; no word is lost or duplicated; the MEM_WDATA sequence equals the input sequence.
REQ-023 Wrap: BASE_ADDR=0xFE, COUNT=4 -> MEM_ADDR sequence 0xFE, 0xFF, 0x00, 0x01; WRAP=1 after the third write.
REQ-024 Boundaries: COUNT=0 -> DONE in the cycle after START with no MEM_WE; START asserted while BUSY -> ignored, captured COUNT unchanged.
REQ-025 Abort: COUNT=6, ABORT after 2 writes -> IDLE next cycle, LOADED=2, no DONE, no MEM_WE afterwards.
REQ-026 Reset mid-load: RST=0 during DRAIN -> all outputs at reset values immediately without waiting for a clock edge; a new START after release loads correctly from BASE_ADDR.
